midori_share_load_ctrl: RTL and testbench

// - Sequencer in front of the 3-share Midori64 TI core. Accepts a 3-share plaintext over valid/ready.
// - Optionally re-shares it with column-reused (non-uniform) randomness, then loads the core and runs it for all rounds.
// - Captures the 3 ciphertext shares and presents them over valid/ready.
// - Sits between the bench/FIFO share source and the TI round datapath.

---
 rtl/midori_share_load_ctrl_pkg.sv | 21 ++
 rtl/midori_column_reshare.sv | 27 ++
 rtl/midori_share_load_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_midori_share_load_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/midori_share_load_ctrl_pkg.sv
// Shared constants, FSM state encoding and the column re-share index helper
// for the Midori64 three-share load controller.
package midori_share_load_ctrl_pkg;

    localparam int ROUNDS_MIDORI64 = 16;
    localparam int NIBBLES         = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Source nibble for output nibble i: every nibble of a 4-nibble group
    // takes its value from the top nibble of one column (nibble 15 = bits[63:60]).
    function automatic int column_src_nibble(input int i);
        return 15 - ((15 - i) / 4);
    endfunction

endpackage

// File: rtl/midori_column_reshare.sv
// Combinational column re-share of a 3-share 64-bit value. Shares 0 and 1 are
// rebuilt from reused column nibbles and share 2 absorbs the difference, so the
// XOR of the three shares is preserved exactly. Only instantiated when
// MIDORI_COLUMN_RESHARE_EN is defined.
module midori_column_reshare
    import midori_share_load_ctrl_pkg::*;
(
    input  logic [63:0] s0_i,
    input  logic [63:0] s1_i,
    input  logic [63:0] s2_i,
    output logic [63:0] s0_o,
    output logic [63:0] s1_o,
    output logic [63:0] s2_o
);

    logic [63:0] x_s;

    assign x_s = s0_i ^ s1_i ^ s2_i;

    for (genvar i = 0; i < NIBBLES; i++) begin : g_nibble
        localparam int K = column_src_nibble(i);
        assign s0_o[4*i +: 4] = s0_i[4*K +: 4];
        assign s1_o[4*i +: 4] = s1_i[4*K +: 4];
        assign s2_o[4*i +: 4] = x_s[4*i +: 4] ^ s0_i[4*K +: 4] ^ s1_i[4*K +: 4];
    end

endmodule

// File: rtl/midori_share_load_ctrl.sv
// Sequencer in front of the 3-share Midori64 TI core: accepts a plaintext
// share triple, optionally re-shares it, loads and runs the core for all
// rounds, then holds the captured ciphertext shares until the sink accepts.
// Optional feature macro: MIDORI_COLUMN_RESHARE_EN (column re-share datapath).
module midori_share_load_ctrl
    import midori_share_load_ctrl_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_MIDORI64,
    parameter int CPR    = 4,
    parameter int CNT_W  = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_share0,
    input  logic [63:0] in_share1,
    input  logic [63:0] in_share2,
    input  logic        reshare_mode,
    output logic        core_load,
    output logic        core_en,
    output logic [3:0]  core_round,
    output logic [63:0] core_share0,
    output logic [63:0] core_share1,
    output logic [63:0] core_share2,
    input  logic [63:0] core_ct0,
    input  logic [63:0] core_ct1,
    input  logic [63:0] core_ct2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_share0,
    output logic [63:0] out_share1,
    output logic [63:0] out_share2,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ROUNDS * CPR - 1);
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(CPR - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  phase_q;
    logic [3:0]        round_q;
    logic              in_ready_q;
    logic              core_load_q;
    logic              core_en_q;
    logic              out_valid_q;
    logic              busy_q;
    logic [63:0]       core_share0_q, core_share1_q, core_share2_q;
    logic [63:0]       out_share0_q, out_share1_q, out_share2_q;
    logic [63:0]       core_share0_d, core_share1_d, core_share2_d;

`ifdef MIDORI_COLUMN_RESHARE_EN
    logic [63:0] rs0_s, rs1_s, rs2_s;

    midori_column_reshare u_reshare (
        .s0_i (in_share0),
        .s1_i (in_share1),
        .s2_i (in_share2),
        .s0_o (rs0_s),
        .s1_o (rs1_s),
        .s2_o (rs2_s)
    );

    // Select re-shared or original shares for capture at the input handshake.
    always_comb begin
        core_share0_d = in_share0;
        core_share1_d = in_share1;
        core_share2_d = in_share2;
        if (reshare_mode) begin
            core_share0_d = rs0_s;
            core_share1_d = rs1_s;
            core_share2_d = rs2_s;
        end else begin
            core_share0_d = in_share0;
            core_share1_d = in_share1;
            core_share2_d = in_share2;
        end
    end
`else
    logic unused_reshare_mode_s;

    assign unused_reshare_mode_s = reshare_mode;

    // Without the re-share datapath the shares pass straight through.
    always_comb begin
        core_share0_d = in_share0;
        core_share1_d = in_share1;
        core_share2_d = in_share2;
    end
`endif

    // Control FSM with registered outputs: IDLE -> LOAD -> RUN -> DONE -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            phase_q       <= '0;
            round_q       <= 4'd0;
            in_ready_q    <= 1'b1;
            core_load_q   <= 1'b0;
            core_en_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            core_share0_q <= 64'd0;
            core_share1_q <= 64'd0;
            core_share2_q <= 64'd0;
            out_share0_q  <= 64'd0;
            out_share1_q  <= 64'd0;
            out_share2_q  <= 64'd0;
        end else begin
            core_load_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        core_share0_q <= core_share0_d;
                        core_share1_q <= core_share1_d;
                        core_share2_q <= core_share2_d;
                        core_load_q   <= 1'b1;
                        in_ready_q    <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= LOAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LOAD: begin
                    cnt_q     <= '0;
                    phase_q   <= '0;
                    round_q   <= 4'd0;
                    core_en_q <= 1'b1;
                    state_q   <= RUN;
                end
                RUN: begin
                    if (cnt_q == CNT_LAST) begin
                        out_share0_q <= core_ct0;
                        out_share1_q <= core_ct1;
                        out_share2_q <= core_ct2;
                        core_en_q    <= 1'b0;
                        out_valid_q  <= 1'b1;
                        round_q      <= 4'd0;
                        cnt_q        <= '0;
                        phase_q      <= '0;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (phase_q == PHASE_LAST) begin
                            phase_q <= '0;
                            round_q <= round_q + 4'd1;
                        end else begin
                            phase_q <= phase_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    core_en_q   <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign core_load   = core_load_q;
    assign core_en     = core_en_q;
    assign core_round  = round_q;
    assign core_share0 = core_share0_q;
    assign core_share1 = core_share1_q;
    assign core_share2 = core_share2_q;
    assign out_valid   = out_valid_q;
    assign out_share0  = out_share0_q;
    assign out_share1  = out_share1_q;
    assign out_share2  = out_share2_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_midori_share_load_ctrl.sv
// Directed bench for midori_share_load_ctrl. A stand-in core latches the
// loaded shares and adds one per enabled cycle, so a correct capture yields
// loaded share + 63 in each ciphertext share.
module tb_midori_share_load_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_share0 = 64'd0, in_share1 = 64'd0, in_share2 = 64'd0;
    logic        reshare_mode = 1'b0;
    logic        core_load, core_en;
    logic [3:0]  core_round;
    logic [63:0] core_share0, core_share1, core_share2;
    logic [63:0] core_ct0 = 64'd0, core_ct1 = 64'd0, core_ct2 = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_share0, out_share1, out_share2;
    logic        busy;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    midori_share_load_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_share0(in_share0), .in_share1(in_share1), .in_share2(in_share2),
        .reshare_mode(reshare_mode),
        .core_load(core_load), .core_en(core_en), .core_round(core_round),
        .core_share0(core_share0), .core_share1(core_share1), .core_share2(core_share2),
        .core_ct0(core_ct0), .core_ct1(core_ct1), .core_ct2(core_ct2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_share0(out_share0), .out_share1(out_share1), .out_share2(out_share2),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in core: load latches shares, each enabled cycle adds one.
    always @(posedge clk) begin
        if (core_load) begin
            core_ct0 <= core_share0;
            core_ct1 <= core_share1;
            core_ct2 <= core_share2;
        end else if (core_en) begin
            core_ct0 <= core_ct0 + 64'd1;
            core_ct1 <= core_ct1 + 64'd1;
            core_ct2 <= core_ct2 + 64'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_handshake(input logic [63:0] s0, input logic [63:0] s1,
                                input logic [63:0] s2, input logic mode);
        in_share0 = s0; in_share1 = s1; in_share2 = s2;
        reshare_mode = mode;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Called in the cycle after the handshake; returns latency from the
    // handshake cycle, enabled-cycle count, round errors and extra loads.
    task automatic wait_done(output int lat, output int ens, output int rnd_err,
                             output int loads);
        lat = 1; ens = 0; rnd_err = 0; loads = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
            if (core_en === 1'b1) begin
                if (core_round !== 4'(ens / 4)) rnd_err++;
                ens++;
            end
            if (core_load === 1'b1) loads++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        tick(); tick();
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++; if (core_load !== 1'b0) begin errors++; $display("FAIL reset_core_load: got %b expected 0", core_load); end
        vectors++; if (core_en !== 1'b0) begin errors++; $display("FAIL reset_core_en: got %b expected 0", core_en); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (core_round !== 4'd0) begin errors++; $display("FAIL reset_core_round: got %0d expected 0", core_round); end
        vectors++; if ((core_share0 | core_share1 | core_share2) !== 64'd0) begin errors++; $display("FAIL reset_core_share: got %h %h %h expected all 0", core_share0, core_share1, core_share2); end
        vectors++; if ((out_share0 | out_share1 | out_share2) !== 64'd0) begin errors++; $display("FAIL reset_out_share: got %h %h %h expected all 0", out_share0, out_share1, out_share2); end
    endtask

    task automatic test_basic();
        int lat, ens, rerr, loads;
        logic [63:0] p;
        p = 64'h0123456789ABCDEF;
        do_handshake(p, 64'd0, 64'd0, 1'b0);
        vectors++; if (core_load !== 1'b1) begin errors++; $display("FAIL basic_core_load: got %b expected 1", core_load); end
        vectors++; if (core_share0 !== p) begin errors++; $display("FAIL basic_core_share0: got %h expected %h", core_share0, p); end
        vectors++; if (core_share1 !== 64'd0) begin errors++; $display("FAIL basic_core_share1: got %h expected 0", core_share1); end
        vectors++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got in_ready=%b busy=%b expected 0/1", in_ready, busy); end
        wait_done(lat, ens, rerr, loads);
        vectors++; if (lat !== 66) begin errors++; $display("FAIL basic_latency: got %0d expected 66", lat); end
        vectors++; if (ens !== 64) begin errors++; $display("FAIL basic_core_en_cycles: got %0d expected 64", ens); end
        vectors++; if (rerr !== 0) begin errors++; $display("FAIL basic_core_round: got %0d bad cycles expected 0", rerr); end
        vectors++; if (loads !== 0) begin errors++; $display("FAIL basic_single_load: got %0d extra pulses expected 0", loads); end
        vectors++; if (out_share0 !== p + 64'd63) begin errors++; $display("FAIL basic_out_share0: got %h expected %h", out_share0, p + 64'd63); end
        vectors++; if (out_share1 !== 64'd63 || out_share2 !== 64'd63) begin errors++; $display("FAIL basic_out_share12: got %h %h expected %h", out_share1, out_share2, 64'd63); end
        release_out();
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_release: got in_ready=%b out_valid=%b busy=%b expected 1/0/0", in_ready, out_valid, busy); end
        vectors++; if (out_share0 !== p + 64'd63) begin errors++; $display("FAIL basic_out_hold_idle: got %h expected %h", out_share0, p + 64'd63); end
    endtask

    task automatic test_reshare();
        int lat, ens, rerr, loads;
        logic [63:0] s0 [2];
        logic [63:0] s1 [2];
        logic [63:0] s2 [2];
        logic [63:0] e0 [2];
        logic [63:0] e1 [2];
        logic [63:0] e2 [2];
        s0[0] = 64'h0123456789ABCDEF; s1[0] = 64'hFEDCBA9876543210; s2[0] = 64'd0;
        s0[1] = 64'h0123456789ABCDEF; s1[1] = 64'd0;                s2[1] = 64'h1111111111111111;
`ifdef MIDORI_COLUMN_RESHARE_EN
        e0[0] = 64'h0000111122223333; e1[0] = 64'hFFFFEEEEDDDDCCCC; e2[0] = 64'd0;
        e0[1] = 64'h0000111122223333; e1[1] = 64'd0;                e2[1] = 64'h10324567BA98EFCD;
`else
        e0[0] = s0[0]; e1[0] = s1[0]; e2[0] = s2[0];
        e0[1] = s0[1]; e1[1] = s1[1]; e2[1] = s2[1];
`endif
        for (int v = 0; v < 2; v++) begin
            do_handshake(s0[v], s1[v], s2[v], 1'b1);
            vectors++; if (core_share0 !== e0[v]) begin errors++; $display("FAIL reshare%0d_share0: got %h expected %h", v, core_share0, e0[v]); end
            vectors++; if (core_share1 !== e1[v]) begin errors++; $display("FAIL reshare%0d_share1: got %h expected %h", v, core_share1, e1[v]); end
            vectors++; if (core_share2 !== e2[v]) begin errors++; $display("FAIL reshare%0d_share2: got %h expected %h", v, core_share2, e2[v]); end
            vectors++; if ((core_share0 ^ core_share1 ^ core_share2) !== (s0[v] ^ s1[v] ^ s2[v])) begin errors++; $display("FAIL reshare%0d_xor: got %h expected %h", v, core_share0 ^ core_share1 ^ core_share2, s0[v] ^ s1[v] ^ s2[v]); end
            wait_done(lat, ens, rerr, loads);
            vectors++; if (lat !== 66 || out_share2 !== e2[v] + 64'd63) begin errors++; $display("FAIL reshare%0d_done: got lat=%0d ct2=%h expected 66 %h", v, lat, out_share2, e2[v] + 64'd63); end
            release_out();
        end
        reshare_mode = 1'b0;
    endtask

    task automatic test_hold();
        int lat, ens, rerr, loads;
        int bad_valid, bad_ready, bad_out, bad_core, bad_load;
        logic [63:0] p, q;
        p = 64'h00000000CAFEF00D;
        q = 64'hAAAAAAAAAAAAAAAA;
        do_handshake(p, 64'd5, 64'd7, 1'b0);
        wait_done(lat, ens, rerr, loads);
        in_share0 = q; in_share1 = q; in_share2 = q;
        in_valid = 1'b1;
        bad_valid = 0; bad_ready = 0; bad_out = 0; bad_core = 0; bad_load = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1) bad_valid++;
            if (in_ready !== 1'b0) bad_ready++;
            if (out_share0 !== p + 64'd63 || out_share1 !== 64'd68 || out_share2 !== 64'd70) bad_out++;
            if (core_share0 !== p) bad_core++;
            if (core_load !== 1'b0) bad_load++;
            tick();
        end
        vectors++; if (bad_valid !== 0) begin errors++; $display("FAIL hold_out_valid: got %0d low cycles expected 0", bad_valid); end
        vectors++; if (bad_ready !== 0) begin errors++; $display("FAIL hold_in_ready: got %0d high cycles expected 0", bad_ready); end
        vectors++; if (bad_out !== 0) begin errors++; $display("FAIL hold_out_stable: got %0d bad cycles expected 0", bad_out); end
        vectors++; if (bad_core !== 0 || bad_load !== 0) begin errors++; $display("FAIL hold_no_capture: got %0d/%0d bad cycles expected 0/0", bad_core, bad_load); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
        tick();
        in_valid = 1'b0;
        vectors++; if (core_load !== 1'b1 || core_share0 !== q) begin errors++; $display("FAIL hold_next_capture: got load=%b share0=%h expected 1 %h", core_load, core_share0, q); end
        wait_done(lat, ens, rerr, loads);
        vectors++; if (out_share0 !== q + 64'd63) begin errors++; $display("FAIL hold_next_out: got %h expected %h", out_share0, q + 64'd63); end
        release_out();
    endtask

    task automatic test_reset_mid();
        int lat, ens, rerr, loads;
        logic [63:0] p;
        p = 64'h1234000000000001;
        do_handshake(p, p, p, 1'b0);
        for (int i = 0; i < 31; i++) tick();
        rst = 1'b1;
        tick();
        vectors++; if (in_ready !== 1'b1 || busy !== 1'b0 || core_en !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got in_ready=%b busy=%b en=%b valid=%b expected 1/0/0/0", in_ready, busy, core_en, out_valid); end
        vectors++; if ((core_share0 | out_share0 | out_share1 | out_share2) !== 64'd0) begin errors++; $display("FAIL rstmid_data: got core=%h out=%h expected 0", core_share0, out_share0); end
        rst = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_partial: got valid=%b busy=%b expected 0/0", out_valid, busy); end
        do_handshake(p, 64'd1, 64'd2, 1'b0);
        wait_done(lat, ens, rerr, loads);
        vectors++; if (lat !== 66) begin errors++; $display("FAIL rstmid_latency: got %0d expected 66", lat); end
        vectors++; if (out_share0 !== p + 64'd63 || out_share2 !== 64'd65) begin errors++; $display("FAIL rstmid_out: got %h %h expected %h %h", out_share0, out_share2, p + 64'd63, 64'd65); end
        release_out();
    endtask

    task automatic test_back_to_back();
        int hs [8];
        int n, run_idx, rerr, guard;
        for (int i = 0; i < 8; i++) hs[i] = 0;
        n = 0; run_idx = 0; rerr = 0;
        in_share0 = 64'h5555; in_share1 = 64'h6666; in_share2 = 64'h7777;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 210; i++) begin
            if (in_valid === 1'b1 && in_ready === 1'b1 && n < 8) begin
                hs[n] = cyc;
                n++;
            end
            if (core_en === 1'b1) begin
                if (core_round !== 4'(run_idx / 4)) rerr++;
                run_idx++;
            end else begin
                run_idx = 0;
            end
            tick();
        end
        in_valid = 1'b0;
        vectors++; if (hs[1] - hs[0] !== 67) begin errors++; $display("FAIL b2b_gap1: got %0d expected 67", hs[1] - hs[0]); end
        vectors++; if (hs[2] - hs[1] !== 67) begin errors++; $display("FAIL b2b_gap2: got %0d expected 67", hs[2] - hs[1]); end
        vectors++; if (rerr !== 0) begin errors++; $display("FAIL b2b_core_round: got %0d bad cycles expected 0", rerr); end
        guard = 0;
        while (busy === 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain: got busy=%b expected 0", busy); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reshare();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
